// File: rtl/icache_dn_responder.sv
// Fixed-latency, strictly in-order downstream responder for icache line fills.
// Echoes the request fields; the response data is the request address zero-extended.
module icache_dn_responder #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned RSP_LATENCY    = 20,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned TXNID_WIDTH    = 5,
    parameter int unsigned ENTRY_ID_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      txreq_vld,
    output logic                      txreq_rdy,
    input  logic [ADDR_WIDTH-1:0]     txreq_addr,
    input  logic [OPCODE_WIDTH-1:0]   txreq_opcode,
    input  logic [TXNID_WIDTH-1:0]    txreq_txnid,
    input  logic [ENTRY_ID_WIDTH-1:0] txreq_entry_id,
    output logic                      rxdat_vld,
    input  logic                      rxdat_rdy,
    output logic [OPCODE_WIDTH-1:0]   rxdat_opcode,
    output logic [TXNID_WIDTH-1:0]    rxdat_txnid,
    output logic [DATA_WIDTH-1:0]     rxdat_data,
    output logic [ENTRY_ID_WIDTH-1:0] rxdat_entry_idx,
    output logic [$clog2(DEPTH):0]    outstanding
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [7:0]  AGE_MAX = 8'(RSP_LATENCY);
    localparam logic [7:0]  AGE_RDY = 8'(RSP_LATENCY - 1);

    logic [ADDR_WIDTH-1:0]     r_addr     [DEPTH];
    logic [OPCODE_WIDTH-1:0]   r_opcode   [DEPTH];
    logic [TXNID_WIDTH-1:0]    r_txnid    [DEPTH];
    logic [ENTRY_ID_WIDTH-1:0] r_entry_id [DEPTH];
    logic [7:0]                r_age      [DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;

    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [PTR_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_occupied;

    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == PTR_W'(DEPTH));
    assign w_empty  = (w_count == '0);
    assign w_push   = txreq_vld && !w_full;
    assign w_pop    = rxdat_vld && rxdat_rdy;

    // An entry is live when its distance from the read index is below the fill count.
    always_comb begin
        logic [IDX_W-1:0] w_off;
        w_off      = '0;
        w_occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off         = IDX_W'(i) - w_rd_idx;
            w_occupied[i] = (PTR_W'(w_off) < w_count);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]     <= '0;
                r_opcode[i]   <= '0;
                r_txnid[i]    <= '0;
                r_entry_id[i] <= '0;
                r_age[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_occupied[i] && (r_age[i] < AGE_MAX)) begin
                    r_age[i] <= r_age[i] + 8'd1;
                end
            end
            // The write slot is never occupied (no push when full), so this cannot clash.
            if (w_push) begin
                r_addr[w_wr_idx]     <= txreq_addr;
                r_opcode[w_wr_idx]   <= txreq_opcode;
                r_txnid[w_wr_idx]    <= txreq_txnid;
                r_entry_id[w_wr_idx] <= txreq_entry_id;
                r_age[w_wr_idx]      <= '0;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign txreq_rdy       = !w_full;
    assign rxdat_vld       = !w_empty && (r_age[w_rd_idx] >= AGE_RDY);
    assign rxdat_opcode    = r_opcode[w_rd_idx];
    assign rxdat_txnid     = r_txnid[w_rd_idx];
    assign rxdat_entry_idx = r_entry_id[w_rd_idx];
    assign rxdat_data      = DATA_WIDTH'(r_addr[w_rd_idx]);
    assign outstanding     = w_count;

endmodule

// File: tb/tb_icache_dn_responder.sv
// Randomized bench for icache_dn_responder against a queue-based timing model,
// plus a second low-latency instance for sustained-throughput wrap-around.
module tb_icache_dn_responder;

    localparam int DEPTH = 8;
    localparam int LAT   = 20;
    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int OW    = 4;
    localparam int TW    = 5;
    localparam int EW    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [OW-1:0] opc;
        logic [TW-1:0] txnid;
        logic [EW-1:0] eid;
        int            t;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          txreq_vld, txreq_rdy, rxdat_vld, rxdat_rdy;
    logic [AW-1:0] txreq_addr;
    logic [OW-1:0] txreq_opcode, rxdat_opcode;
    logic [TW-1:0] txreq_txnid, rxdat_txnid;
    logic [EW-1:0] txreq_entry_id, rxdat_entry_idx;
    logic [DW-1:0] rxdat_data;
    logic [CW-1:0] outstanding;

    logic          b_txreq_vld, b_txreq_rdy, b_rxdat_vld, b_rxdat_rdy;
    logic [AW-1:0] b_txreq_addr;
    logic [OW-1:0] b_txreq_opcode, b_rxdat_opcode;
    logic [TW-1:0] b_txreq_txnid, b_rxdat_txnid;
    logic [EW-1:0] b_txreq_entry_id, b_rxdat_entry_idx;
    logic [DW-1:0] b_rxdat_data;
    logic [CW-1:0] b_outstanding;

    icache_dn_responder #(
        .DEPTH(DEPTH), .RSP_LATENCY(LAT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .OPCODE_WIDTH(OW), .TXNID_WIDTH(TW), .ENTRY_ID_WIDTH(EW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .txreq_vld(txreq_vld), .txreq_rdy(txreq_rdy), .txreq_addr(txreq_addr),
        .txreq_opcode(txreq_opcode), .txreq_txnid(txreq_txnid),
        .txreq_entry_id(txreq_entry_id),
        .rxdat_vld(rxdat_vld), .rxdat_rdy(rxdat_rdy), .rxdat_opcode(rxdat_opcode),
        .rxdat_txnid(rxdat_txnid), .rxdat_data(rxdat_data),
        .rxdat_entry_idx(rxdat_entry_idx), .outstanding(outstanding)
    );

    icache_dn_responder #(
        .DEPTH(DEPTH), .RSP_LATENCY(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .OPCODE_WIDTH(OW), .TXNID_WIDTH(TW), .ENTRY_ID_WIDTH(EW)
    ) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .txreq_vld(b_txreq_vld), .txreq_rdy(b_txreq_rdy), .txreq_addr(b_txreq_addr),
        .txreq_opcode(b_txreq_opcode), .txreq_txnid(b_txreq_txnid),
        .txreq_entry_id(b_txreq_entry_id),
        .rxdat_vld(b_rxdat_vld), .rxdat_rdy(b_rxdat_rdy), .rxdat_opcode(b_rxdat_opcode),
        .rxdat_txnid(b_rxdat_txnid), .rxdat_data(b_rxdat_data),
        .rxdat_entry_idx(b_rxdat_entry_idx), .outstanding(b_outstanding)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of accepted requests with their accept-edge index.
    req_t mq[$];
    req_t stim[$];
    int   cyc = 0;
    bit   drv_acc = 1'b0;
    bit   rdy_rand = 1'b0;
    bit   rdy_fix = 1'b1;
    bit   gate_rand = 1'b0;

    function automatic bit exp_vld();
        return (mq.size() > 0) && ((cyc - mq[0].t) >= (LAT - 1));
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit v;
        bit r;
        req_t n;
        if (rst) begin
            mq.delete();
            drv_acc = 1'b0;
        end else begin
            v = exp_vld();
            r = (mq.size() < DEPTH);
            drv_acc = txreq_vld && txreq_rdy;
            if (v && rxdat_rdy) void'(mq.pop_front());
            if (txreq_vld && r) begin
                n.addr  = txreq_addr;
                n.opc   = txreq_opcode;
                n.txnid = txreq_txnid;
                n.eid   = txreq_entry_id;
                n.t     = cyc + 1;
                mq.push_back(n);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("vld", 256'(rxdat_vld), 256'(exp_vld()));
            check_eq("txreq_rdy", 256'(txreq_rdy), 256'(mq.size() < DEPTH));
            check_eq("outstanding", 256'(outstanding), 256'(mq.size()));
            if (exp_vld() && rxdat_vld) begin
                check_eq("data", 256'(rxdat_data), 256'(mq[0].addr));
                check_eq("opcode", 256'(rxdat_opcode), 256'(mq[0].opc));
                check_eq("txnid", 256'(rxdat_txnid), 256'(mq[0].txnid));
                check_eq("entry_idx", 256'(rxdat_entry_idx), 256'(mq[0].eid));
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
        if (drv_acc) begin
            void'(stim.pop_front());
            drv_acc = 1'b0;
        end
        rxdat_rdy = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
        if (stim.size() > 0 && (!gate_rand || $urandom_range(0, 3) != 0)) begin
            txreq_vld      = 1'b1;
            txreq_addr     = stim[0].addr;
            txreq_opcode   = stim[0].opc;
            txreq_txnid    = stim[0].txnid;
            txreq_entry_id = stim[0].eid;
        end else begin
            txreq_vld  = 1'b0;
            txreq_addr = $urandom;
        end
    endtask

    task automatic add_req(input logic [AW-1:0] a, input logic [OW-1:0] o,
                           input logic [TW-1:0] x, input logic [EW-1:0] e);
        req_t n;
        n.addr = a; n.opc = o; n.txnid = x; n.eid = e; n.t = 0;
        stim.push_back(n);
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        while ((stim.size() > 0 || mq.size() > 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", 256'(stim.size() == 0 && mq.size() == 0), 256'(1));
    endtask

    initial begin
        logic [AW-1:0] bi;
        txreq_vld = 0; txreq_addr = '0; txreq_opcode = '0; txreq_txnid = '0;
        txreq_entry_id = '0; rxdat_rdy = 0;
        b_txreq_vld = 0; b_txreq_addr = '0; b_txreq_opcode = '0; b_txreq_txnid = '0;
        b_txreq_entry_id = '0; b_rxdat_rdy = 1;

        #1 rst = 1'b1;
        #1;
        check_eq("reset_vld", 256'(rxdat_vld), 256'(0));
        check_eq("reset_rdy", 256'(txreq_rdy), 256'(1));
        check_eq("reset_outst", 256'(outstanding), 256'(0));
        check_eq("reset_data", 256'(rxdat_data), 256'(0));
        check_eq("reset_fields", 256'({rxdat_opcode, rxdat_txnid, rxdat_entry_idx}), 256'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Single request.
        rdy_fix = 1'b1;
        add_req(32'h0000_1234, 4'd2, 5'd7, 3'd3);
        run_until_idle(60);

        // Fill to full with the response side stalled, then drain; 8 and 9 enter as slots free.
        rdy_fix = 1'b0;
        for (int i = 0; i < 10; i++) add_req($urandom, 4'($urandom), 5'(i), 3'($urandom));
        repeat (30) cycle();
        check_eq("fill_outst", 256'(outstanding), 256'(DEPTH));
        check_eq("fill_rdy", 256'(txreq_rdy), 256'(0));
        check_eq("fill_vld", 256'(rxdat_vld), 256'(1));
        rdy_fix = 1'b1;
        run_until_idle(200);

        // Backpressure on 4 pending responses.
        rdy_rand = 1'b1;
        for (int i = 0; i < 4; i++) add_req($urandom, 4'($urandom), 5'($urandom), 3'($urandom));
        run_until_idle(300);

        // Random mixed traffic.
        gate_rand = 1'b1;
        for (int i = 0; i < 200; i++) add_req($urandom, 4'($urandom), 5'($urandom), 3'($urandom));
        run_until_idle(4000);
        gate_rand = 1'b0;
        rdy_rand  = 1'b0;

        // Reset with 5 outstanding.
        rdy_fix = 1'b0;
        for (int i = 0; i < 5; i++) add_req($urandom, 4'($urandom), 5'(i), 3'($urandom));
        repeat (8) cycle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_vld", 256'(rxdat_vld), 256'(0));
        check_eq("midrst_outst", 256'(outstanding), 256'(0));
        check_eq("midrst_rdy", 256'(txreq_rdy), 256'(1));
        stim.delete();
        txreq_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        rdy_fix = 1'b1;
        repeat (LAT + 5) cycle();
        add_req(32'hCAFE_0001, 4'd5, 5'd17, 3'd6);
        run_until_idle(60);

        // Wrap-around on the latency-1 instance: one accept and one response per cycle.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                bi = AW'(i - 1);
                check_eq("wrap_vld", 256'(b_rxdat_vld), 256'(1));
                check_eq("wrap_data", 256'(b_rxdat_data), 256'(bi));
                check_eq("wrap_txnid", 256'(b_rxdat_txnid), 256'(bi[TW-1:0]));
                check_eq("wrap_outst", 256'(b_outstanding), 256'(1));
                check_eq("wrap_rdy", 256'(b_txreq_rdy), 256'(1));
            end
            bi = AW'(i);
            b_txreq_vld      = 1'b1;
            b_txreq_addr     = bi;
            b_txreq_opcode   = bi[OW-1:0];
            b_txreq_txnid    = bi[TW-1:0];
            b_txreq_entry_id = bi[EW-1:0];
        end
        @(negedge clk);
        check_eq("wrap_last_vld", 256'(b_rxdat_vld), 256'(1));
        check_eq("wrap_last_data", 256'(b_rxdat_data), 256'(39));
        b_txreq_vld = 1'b0;
        @(negedge clk);
        check_eq("wrap_end_vld", 256'(b_rxdat_vld), 256'(0));
        check_eq("wrap_end_outst", 256'(b_outstanding), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
